// File: rtl/mem_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | mem_arbiter_pkg : shared widths, constants and FSM encoding          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_arbiter_pkg;
  localparam int ADDR_TP = 32;
  localparam int WORD_TP = 32;
  localparam int BYTE_TP = 8;
  localparam int CNT_W   = 7;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [ADDR_TP-1:0] ZERO_ADDR = '0;

  typedef enum logic [1:0] {
    MA_IDLE  = 2'd0,
    MA_IC_RD = 2'd1,
    MA_LS_RD = 2'd2,
    MA_LS_WR = 2'd3
  } ma_state_e;

  // Byte count of an LSU access; anything but 1 or 2 is a word.
  function automatic logic [CNT_W-1:0] ma_size_norm(input logic [2:0] size);
    case (size)
      3'd1:    return CNT_W'(1);
      3'd2:    return CNT_W'(2);
      default: return CNT_W'(4);
    endcase
  endfunction
endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// +----------------------------------------------------------------------+
// | mem_arbiter_if : icache / LSU / byte-RAM bus bundle                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = ADDR_TP
);
  logic                    ic_req;
  logic [ADDR_W-1:0]       ic_addr;
  logic                    ic_done;
  logic [8*LINE_BYTES-1:0] ic_line;
  logic                    ls_req;
  logic                    ls_we;
  logic [2:0]              ls_size;
  logic [ADDR_W-1:0]       ls_addr;
  logic [WORD_TP-1:0]      ls_wdata;
  logic                    ls_done;
  logic [WORD_TP-1:0]      ls_rdata;
  logic [BYTE_TP-1:0]      mem_din;
  logic [BYTE_TP-1:0]      mem_dout;
  logic [ADDR_W-1:0]       mem_a;
  logic                    mem_wr;

  modport slave (
    input  ic_req, ic_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
    output ic_done, ic_line, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output ic_req, ic_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
    input  ic_done, ic_line, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter_byte_seq.sv
// +----------------------------------------------------------------------+
// | mem_byte_seq : byte counter, address stepping, read assembly         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_byte_seq
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = ADDR_TP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    adv,
  input  logic                    stall,
  input  logic                    is_wr,
  input  logic [ADDR_W-1:0]       base,
  input  logic [CNT_W-1:0]        n,
  input  logic [WORD_TP-1:0]      wdata,
  input  logic [BYTE_TP-1:0]      din,
  output logic [ADDR_W-1:0]       addr,
  output logic [BYTE_TP-1:0]      dout,
  output logic                    wr,
  output logic                    last,
  output logic [8*LINE_BYTES-1:0] data
);
  localparam int IDX_W  = $clog2(LINE_BYTES);
  localparam int LINE_W = 8 * LINE_BYTES;

  logic [CNT_W-1:0]   r_cnt, r_n;
  logic [ADDR_W-1:0]  r_base, r_addr;
  logic [WORD_TP-1:0] r_wdata;
  logic [BYTE_TP-1:0] r_dout;
  logic               r_wr, r_is_wr;
  logic [LINE_W-1:0]  r_buf;

  logic               w_more;
  logic [IDX_W-1:0]   w_idx;
  logic [LINE_W-1:0]  w_asm;
  logic [BYTE_TP-1:0] w_wbyte;

  assign w_more  = r_cnt < r_n;
  // RAM returns byte k two edges after its address, so cnt-2 is the slot.
  assign w_idx   = IDX_W'(r_cnt - CNT_W'(2));
  assign w_asm   = r_buf | (LINE_W'(din) << {w_idx, 3'b000});
  assign w_wbyte = BYTE_TP'(r_wdata >> {r_cnt[1:0], 3'b000});

  assign last = r_is_wr ? !w_more : (r_cnt == r_n + CNT_W'(1));
  assign addr = r_addr;
  assign dout = r_dout;
  assign wr   = r_wr;
  assign data = w_asm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_n     <= '0;
      r_base  <= ADDR_W'(ZERO_ADDR);
      r_addr  <= ADDR_W'(ZERO_ADDR);
      r_wdata <= '0;
      r_dout  <= '0;
      r_wr    <= FALSE;
      r_is_wr <= FALSE;
      r_buf   <= '0;
    end else if (start) begin
      r_base  <= base;
      r_n     <= n;
      r_cnt   <= CNT_W'(1);
      r_addr  <= base;
      r_buf   <= '0;
      r_wdata <= wdata;
      r_is_wr <= is_wr;
      r_wr    <= is_wr;
      if (is_wr) r_dout <= wdata[BYTE_TP-1:0];
    end else if (adv) begin
      if (r_is_wr) begin
        // cnt counts bytes already issued; a stall withholds the next one.
        if (w_more && !stall) begin
          r_addr <= r_base + ADDR_W'(r_cnt);
          r_dout <= w_wbyte;
          r_wr   <= TRUE;
          r_cnt  <= r_cnt + CNT_W'(1);
        end else begin
          r_wr <= FALSE;
        end
      end else if (!last) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_more) r_addr <= r_base + ADDR_W'(r_cnt);
        if (r_cnt >= CNT_W'(2)) r_buf <= w_asm;
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_arbiter : icache/LSU arbiter for the byte-wide memory port       |
// | Optional: MEM_ARB_IO_STALL_EN stalls IO stores on io_buffer_full     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         LINE_BYTES = 16,
  parameter int         ADDR_W     = ADDR_TP,
  parameter logic [1:0] IO_HI      = 2'b11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         flush,
  input  logic         io_buffer_full,
  mem_arbiter_if.slave bus
);
  ma_state_e               r_state;
  logic                    r_last_ls;
  logic                    r_ic_done, r_ls_done;
  logic [8*LINE_BYTES-1:0] r_ic_line;
  logic [WORD_TP-1:0]      r_ls_rdata;

  logic                    w_io_block, w_io_stall;
  logic                    w_ic_elig, w_ls_elig, w_pick_ls, w_grant;
  logic                    w_start, w_adv, w_rd_flush;
  logic [ADDR_W-1:0]       w_addr;
  logic [BYTE_TP-1:0]      w_dout;
  logic                    w_wr, w_last;
  logic [8*LINE_BYTES-1:0] w_data;

`ifdef MEM_ARB_IO_STALL_EN
  logic r_io_dst;
  assign w_io_block = bus.ls_we && (bus.ls_addr[17:16] == IO_HI) && io_buffer_full;
  assign w_io_stall = r_io_dst && io_buffer_full;
`else
  logic w_unused_io;
  assign w_unused_io = &{1'b0, io_buffer_full, IO_HI};
  assign w_io_block  = FALSE;
  assign w_io_stall  = FALSE;
`endif

  // A requester whose done is showing still holds req; never re-grant it.
  assign w_ic_elig  = bus.ic_req && !r_ic_done;
  assign w_ls_elig  = bus.ls_req && !r_ls_done && !w_io_block;
  assign w_pick_ls  = w_ls_elig && (!w_ic_elig || !r_last_ls);
  assign w_grant    = (r_state == MA_IDLE) && !flush && (w_ic_elig || w_ls_elig);
  assign w_start    = rdy && w_grant;
  assign w_rd_flush = flush && ((r_state == MA_IC_RD) || (r_state == MA_LS_RD));
  assign w_adv      = rdy && (r_state != MA_IDLE) && !w_rd_flush;

  mem_byte_seq #(
    .LINE_BYTES (LINE_BYTES),
    .ADDR_W     (ADDR_W)
  ) u_seq (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .adv   (w_adv),
    .stall (w_io_stall && (r_state == MA_LS_WR)),
    .is_wr (w_pick_ls && bus.ls_we),
    .base  (w_pick_ls ? bus.ls_addr : bus.ic_addr),
    .n     (w_pick_ls ? ma_size_norm(bus.ls_size) : CNT_W'(LINE_BYTES)),
    .wdata (bus.ls_wdata),
    .din   (bus.mem_din),
    .addr  (w_addr),
    .dout  (w_dout),
    .wr    (w_wr),
    .last  (w_last),
    .data  (w_data)
  );

  assign bus.mem_a    = w_addr;
  assign bus.mem_dout = w_dout;
  assign bus.mem_wr   = w_wr && rdy;
  assign bus.ic_done  = r_ic_done;
  assign bus.ic_line  = r_ic_line;
  assign bus.ls_done  = r_ls_done;
  assign bus.ls_rdata = r_ls_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= MA_IDLE;
      r_last_ls  <= FALSE;
      r_ic_done  <= FALSE;
      r_ls_done  <= FALSE;
      r_ic_line  <= '0;
      r_ls_rdata <= '0;
`ifdef MEM_ARB_IO_STALL_EN
      r_io_dst   <= FALSE;
`endif
    end else if (rdy) begin
      r_ic_done <= FALSE;
      r_ls_done <= FALSE;
      case (r_state)
        MA_IDLE: begin
          if (w_grant) begin
            r_last_ls <= w_pick_ls;
`ifdef MEM_ARB_IO_STALL_EN
            r_io_dst  <= bus.ls_addr[17:16] == IO_HI;
`endif
            if (!w_pick_ls)     r_state <= MA_IC_RD;
            else if (bus.ls_we) r_state <= MA_LS_WR;
            else                r_state <= MA_LS_RD;
          end
        end
        MA_IC_RD: begin
          if (flush) begin
            r_state <= MA_IDLE;
          end else if (w_last) begin
            r_state   <= MA_IDLE;
            r_ic_done <= TRUE;
            r_ic_line <= w_data;
          end
        end
        MA_LS_RD: begin
          if (flush) begin
            r_state <= MA_IDLE;
          end else if (w_last) begin
            r_state    <= MA_IDLE;
            r_ls_done  <= TRUE;
            r_ls_rdata <= w_data[WORD_TP-1:0];
          end
        end
        MA_LS_WR: begin
          if (w_last) begin
            r_state   <= MA_IDLE;
            r_ls_done <= TRUE;
          end
        end
        default: r_state <= MA_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire
